// File: rtl/mcac_g711_pkg.sv
// mcac_g711_pkg: shared types and constants for the G.711 expander datapath
package mcac_g711_pkg;
   typedef enum logic [1:0] {IDLE, SHIFT, FIN, DONE} state_t;
   localparam int         ULAW_BIAS = 33;
   localparam logic [7:0] ALAW_XOR  = 8'h55;
   localparam int         SL_W      = 14;
endpackage

// File: rtl/expand_seg_decode.sv
// expand_seg_decode: PCM code to sign, biased segment base and shift count
module expand_seg_decode
   import mcac_g711_pkg::*;
(
   input  logic [7:0] sp,
   input  logic       law,
   output logic       neg,
   output logic [6:0] base,
   output logic [2:0] n
);
   logic [7:0] c;
   logic       alaw_e0;
   // A-law segment 0 has no implicit leading one and still needs the final x2
   always_comb begin
      c       = law ? sp ^ ALAW_XOR : ~sp;
      alaw_e0 = law && c[6:4] == 3'd0;
      neg     = law ? ~c[7] : c[7];
      base    = {2'b00, c[3:0], 1'b1} + (alaw_e0 ? 7'd0 : 7'd32);
      n       = alaw_e0 ? 3'd1 : c[6:4];
   end
endmodule

// File: rtl/expand_seq.sv
// expand_seq: iterative G.711 expander, one segment-shift bit per clock
module expand_seq
   import mcac_g711_pkg::*;
(
   input  logic            clk,
   input  logic            rstn,
   input  logic [7:0]      SP,
   input  logic            LAW,
   input  logic            in_valid,
   output logic            in_ready,
   output logic [SL_W-1:0] SL,
   output logic            out_valid,
   input  logic            out_ready
);
   localparam logic [SL_W-1:0] BIAS = SL_W'(ULAW_BIAS);
   state_t          state;
   logic [SL_W-1:0] mag;
   logic [2:0]      cnt;
   logic            neg_q, law_q, fin_ph;
   logic            dec_neg;
   logic [6:0]      dec_base;
   logic [2:0]      dec_n;
   expand_seg_decode u_dec (
      .sp   (SP),
      .law  (LAW),
      .neg  (dec_neg),
      .base (dec_base),
      .n    (dec_n)
   );
   // FSM: latch code, shift one bit per clock, remove bias, then sign-apply and hold
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         state     <= IDLE;
         mag       <= '0;
         cnt       <= '0;
         neg_q     <= 1'b0;
         law_q     <= 1'b0;
         fin_ph    <= 1'b0;
         SL        <= '0;
         out_valid <= 1'b0;
         in_ready  <= 1'b0;
      end else begin
         case (state)
            IDLE:
               if (in_valid && in_ready) begin
                  mag      <= SL_W'(dec_base);
                  cnt      <= dec_n;
                  neg_q    <= dec_neg;
                  law_q    <= LAW;
                  fin_ph   <= 1'b0;
                  in_ready <= 1'b0;
                  state    <= dec_n != 3'd0 ? SHIFT : FIN;
               end else
                  in_ready <= 1'b1;
            SHIFT: begin
               mag <= mag << 1;
               cnt <= cnt - 3'd1;
               if (cnt == 3'd1) state <= FIN;
            end
            FIN:
               if (!fin_ph) begin
                  mag    <= mag - (law_q ? '0 : BIAS);
                  fin_ph <= 1'b1;
               end else begin
                  SL        <= neg_q ? -mag : mag;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            DONE:
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_expand_seq.sv
// tb_expand_seq: randomized and directed check of expand_seq against a G.711 reference model
module tb_expand_seq;
   logic        clk = 1'b0;
   logic        rstn, LAW, in_valid, out_ready;
   logic [7:0]  SP;
   logic        in_ready, out_valid;
   logic [13:0] SL;

   typedef struct {logic [13:0] sl; int due;} exp_t;
   exp_t        exp_q[$];
   int          vectors = 0, errs = 0, cyc = 0, acc_cnt = 0, hs_cnt = 0;
   bit          armed = 0;
   logic [13:0] last_sl;

   expand_seq dut (
      .clk       (clk),
      .rstn      (rstn),
      .SP        (SP),
      .LAW       (LAW),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .SL        (SL),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   // reference expand in the style of the classic G.711 C code (16-bit scale, then /4)
   function automatic logic [13:0] model_sl(input logic [7:0] sp, input logic law);
      logic [7:0] a;
      int t, seg;
      if (law) begin
         a   = sp ^ 8'h55;
         t   = int'(a[3:0]) << 4;
         seg = int'(a[6:4]);
         if (seg == 0) t = t + 8;
         else t = (t + 264) << (seg - 1);
         t = a[7] ? t : -t;
      end else begin
         a   = ~sp;
         seg = int'(a[6:4]);
         t   = ((int'(a[3:0]) << 3) + 132) << seg;
         t   = a[7] ? 132 - t : t - 132;
      end
      return 14'(t / 4);
   endfunction

   function automatic int model_lat(input logic [7:0] sp, input logic law);
      int seg;
      seg = law ? int'((sp ^ 8'h55) >> 4) & 7 : int'((~sp) >> 4) & 7;
      return (law && seg == 0 ? 1 : seg) + 2;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   always @(negedge rstn) begin
      exp_q.delete();
      armed = 0;
   end

   // accept/handshake monitor feeding the expected-output queue
   always @(posedge clk)
      if (rstn) begin
         cyc++;
         armed = 1;
         if (in_valid && in_ready) begin
            exp_q.push_back('{sl: model_sl(SP, LAW), due: cyc + model_lat(SP, LAW)});
            acc_cnt++;
         end
         if (out_valid && out_ready) begin
            hs_cnt++;
            last_sl = SL;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
         end
      end

   // per-cycle compare against the model
   always @(negedge clk)
      if (rstn && armed) begin
         chk("out_valid", int'(out_valid), int'(exp_q.size() != 0 && cyc >= exp_q[0].due));
         chk("in_ready", int'(in_ready), int'(exp_q.size() == 0));
         if (out_valid && exp_q.size() != 0) chk("sl", int'(SL), int'(exp_q[0].sl));
      end

   task automatic xfer(input logic [7:0] sp, input logic law, input int stall);
      int a0, h0;
      a0 = acc_cnt;
      h0 = hs_cnt;
      SP = sp;
      LAW = law;
      in_valid = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (acc_cnt != a0) break;
      end
      in_valid = 1'b0;
      SP = 8'($urandom);
      LAW = 1'($urandom);
      chk("accept", acc_cnt - a0, 1);
      for (int k = 0; k < 200; k++) begin
         out_ready = stall == 0 || $urandom_range(0, stall) == 0;
         @(negedge clk);
         if (hs_cnt != h0) break;
      end
      chk("handshake", hs_cnt - h0, 1);
   endtask

   logic [7:0]  d_sp [8] = '{8'hFF, 8'h80, 8'h00, 8'hD5, 8'h55, 8'hAA, 8'h2A, 8'h7F};
   logic        d_law[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
   logic [13:0] d_sl [8] = '{14'h0000, 14'h1F5F, 14'h20A1, 14'h0002, 14'h3FFE, 14'h1F80, 14'h2080, 14'h0000};
   int          d_lat[8] = '{2, 9, 9, 3, 3, 9, 9, 2};

   initial begin
      int a0, h0;
      rstn = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      SP = 8'h00;
      LAW = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_sl", int'(SL), 0);
      rstn = 1'b1;
      @(negedge clk);
      chk("in_ready_after_rst", int'(in_ready), 1);

      for (int i = 0; i < 8; i++) begin
         chk("model_sl_pin", int'(model_sl(d_sp[i], d_law[i])), int'(d_sl[i]));
         chk("model_lat_pin", model_lat(d_sp[i], d_law[i]), d_lat[i]);
         xfer(d_sp[i], d_law[i], 0);
         chk("directed_sl", int'(last_sl), int'(d_sl[i]));
      end

      a0 = acc_cnt;
      h0 = hs_cnt;
      SP = 8'h80;
      LAW = 1'b0;
      out_ready = 1'b0;
      in_valid = 1'b1;
      for (int k = 0; k < 20 && !out_valid; k++) begin
         @(negedge clk);
         if (acc_cnt != a0) in_valid = 1'b0;
      end
      chk("bp_out_valid_rise", int'(out_valid), 1);
      for (int k = 0; k < 10; k++) begin
         in_valid = k >= 3 && k < 6;
         SP = 8'hFF;
         @(negedge clk);
         chk("bp_sl", int'(SL), 14'h1F5F);
         chk("bp_out_valid", int'(out_valid), 1);
         chk("bp_in_ready", int'(in_ready), 0);
      end
      in_valid = 1'b0;
      chk("bp_no_accept", acc_cnt - a0, 1);
      out_ready = 1'b1;
      for (int k = 0; k < 5 && hs_cnt == h0; k++) @(negedge clk);
      chk("bp_release", hs_cnt - h0, 1);

      a0 = acc_cnt;
      SP = 8'h00;
      LAW = 1'b0;
      in_valid = 1'b1;
      for (int k = 0; k < 20 && acc_cnt == a0; k++) @(negedge clk);
      in_valid = 1'b0;
      chk("rst_mid_accept", acc_cnt - a0, 1);
      repeat (2) @(negedge clk);
      rstn = 1'b0;
      #1;
      chk("rst_mid_out_valid", int'(out_valid), 0);
      chk("rst_mid_sl", int'(SL), 0);
      chk("rst_mid_in_ready", int'(in_ready), 0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      xfer(8'hFF, 1'b0, 0);
      chk("post_rst_sl", int'(last_sl), 0);

      for (int l = 0; l < 2; l++)
         for (int c = 0; c < 256; c++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            xfer(8'(c), 1'(l), $urandom_range(0, 3));
         end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
